// File: rtl/dram_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dram_arb_pkg
// Definitions shared by the DRAM round-robin arbiter and its picker:
//   - state_t : sequencer states (IDLE / ACCESS / RDATA)
//   - DEF_AW  : default DRAM address width
//   - DEF_DW  : default DRAM data width
//   - idx_w() : width of an owner/pointer index for a given requester count
// ----------------------------------------------------------------------------
package dram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDATA  = 2'd2
   } state_t;

   localparam int DEF_AW = 8;
   localparam int DEF_DW = 8;

   // A single requester still needs a 1-bit index to keep vectors legal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dram_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker with an optional priority override.
// Ports:
//   req      in  N   request vector
//   ptr      in  IW  last normal winner; the search starts at ptr+1 (mod N)
//   prio_en  in  1   force prio_idx to win (caller guarantees req[prio_idx])
//   prio_idx in  IW  index forced to win when prio_en is high
//   grant    out N   one-hot winner
//   idx      out IW  binary winner index
//   any      out 1   at least one request is pending
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          prio_en,
   input  logic [IW-1:0] prio_idx,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic found_s;
   int   cand_s;

   // Winner search: forced index, else first request after ptr, wrapping.
   always_comb begin
      grant   = '0;
      idx     = '0;
      any     = |req;
      found_s = 1'b0;
      cand_s  = 0;
      if (prio_en) begin
         grant[prio_idx] = 1'b1;
         idx             = prio_idx;
      end else begin
         for (int k = 1; k <= N; k++) begin
            cand_s = (int'(ptr) + k) % N;
            if (!found_s && req[cand_s]) begin
               found_s        = 1'b1;
               grant[cand_s]  = 1'b1;
               idx            = IW'(cand_s);
            end else begin
               found_s = found_s;
            end
         end
      end
   end

endmodule

// File: rtl/dram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// dram_rr_arbiter
// Shares one single-port synchronous DRAM (registered address, q valid the
// next cycle) between NUM_REQ cores with round-robin arbitration, a
// request/done handshake, per-core read-data hold registers and a bounded
// bus lock for read-modify-write sequences.
// Ports:
//   clk        in  1           system clock
//   rst        in  1           asynchronous reset, active low
//   rden/wren  in  NUM_REQ     per-core read/write request, held until done
//   lock       in  NUM_REQ     per-core bus-lock request
//   Address    in  NUM_REQ*AW  packed addresses, core i at [i*AW +: AW]
//   Din        in  NUM_REQ*DW  packed write data
//   RAMq       in  DW          DRAM read data
//   acq        out NUM_REQ     one-hot grant during ACCESS/RDATA
//   done       out NUM_REQ     one-hot single-cycle completion strobe
//   Dq         out NUM_REQ*DW  per-core read data
//   RAMAddress out AW          DRAM address
//   RAMDin     out DW          DRAM write data
//   RAMwren    out 1           DRAM write enable
// ----------------------------------------------------------------------------
module dram_rr_arbiter
   import dram_arb_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    rden,
   input  logic [NUM_REQ-1:0]    wren,
   input  logic [NUM_REQ-1:0]    lock,
   input  logic [NUM_REQ*AW-1:0] Address,
   input  logic [NUM_REQ*DW-1:0] Din,
   input  logic [DW-1:0]         RAMq,
   output logic [NUM_REQ-1:0]    acq,
   output logic [NUM_REQ-1:0]    done,
   output logic [NUM_REQ*DW-1:0] Dq,
   output logic [AW-1:0]         RAMAddress,
   output logic [DW-1:0]         RAMDin,
   output logic                  RAMwren
);

   localparam int          IW       = idx_w(NUM_REQ);
   localparam logic [3:0]  HOLD_MAX = 4'(MAX_HOLD);

   state_t                state_r, state_nxt_s;
   logic [IW-1:0]         owner_r, ptr_r, win_idx_s;
   logic [3:0]            hold_cnt_r;
   logic [NUM_REQ*DW-1:0] dq_hold_r;
   logic [NUM_REQ-1:0]    req_s, win_grant_s;
   logic                  win_any_s, owner_req_s, owner_wr_s, owner_lock_s;
   logic                  lock_valid_s, prio_en_s, pick_s, complete_s;

   // A write request wins over a simultaneous read request from the same core.
   assign req_s        = rden | wren;
   assign owner_req_s  = req_s[owner_r];
   assign owner_wr_s   = wren[owner_r];
   assign owner_lock_s = lock[owner_r];

   // hold_cnt is non-zero only after a completion with lock held, so the lock
   // can only extend an ownership that actually ran a locked transaction.
   assign lock_valid_s = owner_lock_s && (hold_cnt_r != 4'd0) && (hold_cnt_r < HOLD_MAX);
   assign prio_en_s    = lock_valid_s && owner_req_s;
   assign pick_s       = (state_r == IDLE) && win_any_s;
   assign complete_s   = owner_req_s &&
                         (((state_r == ACCESS) && owner_wr_s) || (state_r == RDATA));

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req      (req_s),
      .ptr      (ptr_r),
      .prio_en  (prio_en_s),
      .prio_idx (owner_r),
      .grant    (win_grant_s),
      .idx      (win_idx_s),
      .any      (win_any_s)
   );

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state; a dropped owner request aborts straight back to IDLE.
   always_comb begin
      state_nxt_s = IDLE;
      case (state_r)
         IDLE: begin
            if (win_any_s) begin
               state_nxt_s = ACCESS;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS: begin
            if (owner_req_s && !owner_wr_s) begin
               state_nxt_s = RDATA;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RDATA:   state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Owner, round-robin pointer, lock hold counter and read hold registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_r    <= '0;
         ptr_r      <= IW'(NUM_REQ - 1);
         hold_cnt_r <= 4'd0;
         dq_hold_r  <= '0;
      end else if (pick_s) begin
         owner_r <= win_idx_s;
         // Locked picks leave the pointer alone so rotation resumes afterwards.
         if (!prio_en_s) begin
            ptr_r <= win_idx_s;
            if (!win_grant_s[owner_r]) begin
               hold_cnt_r <= 4'd0;
            end
         end
      end else if (complete_s) begin
         if (owner_lock_s) begin
            if (hold_cnt_r < HOLD_MAX) begin
               hold_cnt_r <= hold_cnt_r + 4'd1;
            end
         end else begin
            hold_cnt_r <= 4'd0;
         end
         if (state_r == RDATA) begin
            dq_hold_r[owner_r*DW +: DW] <= RAMq;
         end
      end
   end

   // Grant, completion strobe, DRAM drive and read-data bypass.
   always_comb begin
      acq        = '0;
      done       = '0;
      RAMAddress = '0;
      RAMDin     = '0;
      RAMwren    = 1'b0;
      Dq         = dq_hold_r;
      case (state_r)
         ACCESS: begin
            acq[owner_r] = 1'b1;
            RAMAddress   = Address[owner_r*AW +: AW];
            RAMDin       = Din[owner_r*DW +: DW];
            RAMwren      = owner_wr_s;
            done[owner_r] = complete_s;
         end
         RDATA: begin
            acq[owner_r] = 1'b1;
            RAMAddress   = Address[owner_r*AW +: AW];
            if (owner_req_s) begin
               Dq[owner_r*DW +: DW] = RAMq;
               done[owner_r]        = 1'b1;
            end else begin
               Dq = dq_hold_r;
            end
         end
         default: begin
            acq = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dram_rr_arbiter
// Scoreboard bench: scripted core drivers issue transactions and push the
// hand-computed completions into exp_q; a forked monitor pops and compares on
// every done strobe. A behavioural DRAM model sits on the RAM port.
// ----------------------------------------------------------------------------
module tb_dram_rr_arbiter;
   import dram_arb_pkg::*;

   localparam int NR = 2;

   typedef struct {
      int         core;
      bit         wr;
      bit         rd;
      logic [7:0] addr;
      logic [7:0] din;
      bit         lk;
      int         hold;   // 0: hold until done, else drop after this many cycles
      int         dly;    // idle cycles before presenting
   } txn_t;

   typedef struct {
      int         core;
      bit         rd;
      logic [7:0] data;
      int         lat;    // 0: latency not checked
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NR-1:0]   rden, wren, lock, acq, done;
   logic [NR*8-1:0] Address, Din, Dq;
   logic [7:0]      RAMq, RAMAddress, RAMDin;
   logic            RAMwren;

   logic [7:0] mem [256];
   logic       pl_clr, pl_en;
   logic [7:0] pl_addr, pl_data;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   mon_en = 1'b1;
   int   acq_cycles [NR];
   int   wr_pulses;
   int   present_cyc [NR];
   int   done_cyc_q [$];
   exp_t exp_q [$];
   txn_t scr [$];
   txn_t cur [NR];
   bit   act [NR];
   int   cnt [NR];
   int   wt [NR];

   dram_rr_arbiter #(
      .NUM_REQ  (NR),
      .AW       (8),
      .DW       (8),
      .MAX_HOLD (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rden       (rden),
      .wren       (wren),
      .lock       (lock),
      .Address    (Address),
      .Din        (Din),
      .RAMq       (RAMq),
      .acq        (acq),
      .done       (done),
      .Dq         (Dq),
      .RAMAddress (RAMAddress),
      .RAMDin     (RAMDin),
      .RAMwren    (RAMwren)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port synchronous DRAM with a preload/clear back door.
   always @(posedge clk) begin
      if (pl_clr) begin
         for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (RAMwren) begin
         mem[RAMAddress] <= RAMDin;
      end
      RAMq <= mem[RAMAddress];
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic void add_txn(input int c, input bit wr, input bit rd, input logic [7:0] a,
                                   input logic [7:0] d, input bit lk, input int hold, input int dly);
      txn_t t;
      t.core = c; t.wr = wr; t.rd = rd; t.addr = a; t.din = d; t.lk = lk; t.hold = hold; t.dly = dly;
      scr.push_back(t);
   endfunction

   function automatic void add_exp(input int c, input bit rd, input logic [7:0] d, input int lat);
      exp_t e;
      e.core = c; e.rd = rd; e.data = d; e.lat = lat;
      exp_q.push_back(e);
   endfunction

   function automatic int find_txn(input int c);
      for (int j = 0; j < scr.size(); j++) begin
         if (scr[j].core == c) return j;
      end
      return -1;
   endfunction

   // One driver cycle: sample done at negedge, react #1 after the next posedge.
   task automatic drive_step();
      logic [NR-1:0] d;
      @(negedge clk);
      d = done;
      @(posedge clk);
      #1;
      for (int c = 0; c < NR; c++) begin
         if (act[c]) begin
            cnt[c]++;
            if ((cur[c].hold == 0 && d[c]) || (cur[c].hold != 0 && cnt[c] >= cur[c].hold))
               act[c] = 1'b0;
         end
         if (!act[c]) begin
            int j;
            j = find_txn(c);
            if (j >= 0) begin
               if (wt[c] < scr[j].dly) begin
                  wt[c]++;
               end else begin
                  cur[c] = scr[j];
                  scr.delete(j);
                  act[c] = 1'b1;
                  cnt[c] = 0;
                  wt[c]  = 0;
                  present_cyc[c] = cyc;
               end
            end
         end
         rden[c]         = act[c] && cur[c].rd;
         wren[c]         = act[c] && cur[c].wr;
         lock[c]         = act[c] && cur[c].lk;
         Address[c*8 +: 8] = act[c] ? cur[c].addr : 8'h00;
         Din[c*8 +: 8]     = act[c] ? cur[c].din  : 8'h00;
      end
   endtask

   task automatic run(input int max_cyc);
      int n;
      n = 0;
      while ((scr.size() != 0 || act[0] || act[1] || exp_q.size() != 0) && n < max_cyc) begin
         drive_step();
         n++;
      end
      check("run_complete", (n < max_cyc), 1);
      repeat (2) drive_step();
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && mon_en) begin
            for (int i = 0; i < NR; i++) if (acq[i]) acq_cycles[i]++;
            if (RAMwren) wr_pulses++;
            if (done != '0) begin
               check("done_onehot", $onehot(done), 1);
               for (int i = 0; i < NR; i++) begin
                  if (done[i]) begin
                     if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: core %0d strobed done, none expected", i);
                     end else begin
                        e = exp_q.pop_front();
                        check("done_core", i, e.core);
                        if (e.rd) check("read_data", Dq[i*8 +: 8], e.data);
                        if (e.lat != 0) check("latency", cyc - present_cyc[i] + 1, e.lat);
                        done_cyc_q.push_back(cyc);
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      rden = '0; wren = '0; lock = '0; Address = '0; Din = '0;
      for (int c = 0; c < NR; c++) begin
         act[c] = 1'b0; wt[c] = 0; cnt[c] = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic clear_stats();
      for (int c = 0; c < NR; c++) acq_cycles[c] = 0;
      wr_pulses = 0;
      done_cyc_q.delete();
   endtask

   initial begin
      rden = '0; wren = '0; lock = '0; Address = '0; Din = '0;
      pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00; pl_clr = 1'b1;
      fork
         monitor();
      join_none
      @(posedge clk);
      #1 pl_clr = 1'b0;
      do_reset();
      @(negedge clk);
      check("rst_acq", acq, 0);
      check("rst_done", done, 0);
      check("rst_wren", RAMwren, 0);
      check("rst_dq", Dq, 0);
      check("rst_addr", RAMAddress, 0);

      // Single read by core 1.
      preload(8'h10, 8'hA5);
      clear_stats();
      add_txn(1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 0, 0);
      add_exp(1, 1'b1, 8'hA5, 3);
      run(40);
      check("s1_acq1_cycles", acq_cycles[1], 2);
      check("s1_acq0_cycles", acq_cycles[0], 0);
      check("s1_dq1_hold", Dq[15:8], 8'hA5);
      check("s1_no_write", wr_pulses, 0);

      // Read and write together: treated as a single write.
      clear_stats();
      add_txn(0, 1'b1, 1'b1, 8'h05, 8'h3C, 1'b0, 0, 0);
      add_exp(0, 1'b0, 8'h00, 2);
      run(40);
      check("s2_mem", mem[8'h05], 8'h3C);
      check("s2_dq0_unchanged", Dq[7:0], 8'h00);
      check("s2_write_pulses", wr_pulses, 1);
      check("s2_dq1_still", Dq[15:8], 8'hA5);

      // Contention: both cores write back to back, grants alternate 0,1,...
      do_reset();
      clear_stats();
      for (int j = 0; j < 3; j++) begin
         add_txn(0, 1'b1, 1'b0, 8'h30, 8'h01 + 8'(j), 1'b0, 0, 0);
         add_txn(1, 1'b1, 1'b0, 8'h31, 8'h11 + 8'(j), 1'b0, 0, 0);
         add_exp(0, 1'b0, 8'h00, 0);
         add_exp(1, 1'b0, 8'h00, 0);
      end
      run(80);
      check("s3_done_count", done_cyc_q.size(), 6);
      for (int k = 1; k < done_cyc_q.size(); k++)
         check("s3_done_spacing", done_cyc_q[k] - done_cyc_q[k-1], 2);
      check("s3_mem0", mem[8'h30], 8'h03);
      check("s3_mem1", mem[8'h31], 8'h13);
      check("s3_write_pulses", wr_pulses, 6);

      // Lock bound: core 0 keeps the bus for exactly 4 writes, then core 1.
      do_reset();
      clear_stats();
      for (int j = 0; j < 8; j++) add_txn(0, 1'b1, 1'b0, 8'h40, 8'h50 + 8'(j), 1'b1, 0, 0);
      for (int j = 0; j < 2; j++) add_txn(1, 1'b1, 1'b0, 8'h41, 8'h90 + 8'(j), 1'b0, 0, 0);
      for (int r = 0; r < 2; r++) begin
         for (int j = 0; j < 4; j++) add_exp(0, 1'b0, 8'h00, 0);
         add_exp(1, 1'b0, 8'h00, 0);
      end
      run(120);
      check("s4_mem0", mem[8'h40], 8'h57);
      check("s4_mem1", mem[8'h41], 8'h91);
      check("s4_write_pulses", wr_pulses, 10);

      // Abort: core 0 drops its read during ACCESS, core 1 is served next.
      preload(8'h60, 8'hC3);
      add_txn(0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 0, 0);
      add_exp(0, 1'b1, 8'hA5, 3);
      run(40);
      check("s5_dq0_preread", Dq[7:0], 8'hA5);
      clear_stats();
      add_txn(0, 1'b0, 1'b1, 8'h60, 8'h00, 1'b0, 1, 0);
      add_txn(1, 1'b1, 1'b0, 8'h50, 8'h66, 1'b0, 0, 1);
      add_exp(1, 1'b0, 8'h00, 0);
      run(40);
      check("s5_dq0_unchanged", Dq[7:0], 8'hA5);
      check("s5_mem", mem[8'h50], 8'h66);
      check("s5_write_pulses", wr_pulses, 1);
      check("s5_acq0_cycles", acq_cycles[0], 1);
      check("s5_acq1_cycles", acq_cycles[1], 1);

      // Reset asserted in the middle of a write.
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      wren[0] = 1'b1; Address[7:0] = 8'h20; Din[7:0] = 8'h77;
      @(posedge clk);
      @(negedge clk);
      check("s6_access_wren", RAMwren, 1);
      check("s6_access_acq", acq, 2'b01);
      #2 rst = 1'b0;
      #1;
      check("s6_rst_wren", RAMwren, 0);
      check("s6_rst_acq", acq, 0);
      check("s6_rst_done", done, 0);
      check("s6_rst_addr", RAMAddress, 0);
      check("s6_rst_din", RAMDin, 0);
      wren[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("s6_state_idle", dut.state_r, IDLE);
      check("s6_acq", acq, 0);
      check("s6_dq_cleared", Dq, 0);
      check("s6_no_write", mem[8'h20], 8'h00);

      check("exp_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
